// File: rtl/uart_word_serdes_pkg.sv
// Shared definitions for uart_word_serdes: transfer size encodings and FSM states.
package uart_word_serdes_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TX   = 2'd1,
        ST_RX   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Size 2'b11 is treated as a full word.
    function automatic logic [2:0] size_to_count(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_to_count = 3'd1;
            SIZE_HALF: size_to_count = 3'd2;
            default:   size_to_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/uart_word_serdes.sv
// Serialises/deserialises 1/2/4-byte words over a byte-wide UART handshake.
// Byte order: define UART_SERDES_LITTLE_ENDIAN_EN for LSB-first, otherwise MSB-first.
module uart_word_serdes
    import uart_word_serdes_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        order,
    input  logic        write_flag,
    input  logic [1:0]  size,
    input  logic [31:0] o_data,
    output logic        accepted,
    output logic        done,
    output logic [31:0] i_data,
    output logic        busy,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready
);

    state_t      state_q, state_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] idata_q, idata_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        accepted_q, accepted_d;

    logic [2:0]  pos;
    logic [7:0]  cur_byte;

    // pos is the byte lane of the current transfer, derived from the remaining count.
    always_comb begin
`ifdef UART_SERDES_LITTLE_ENDIAN_EN
        pos = nbytes_q - cnt_q;
`else
        pos = cnt_q - 3'd1;
`endif
        case (pos)
            3'd0:    cur_byte = wdata_q[7:0];
            3'd1:    cur_byte = wdata_q[15:8];
            3'd2:    cur_byte = wdata_q[23:16];
            default: cur_byte = wdata_q[31:24];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wdata_d    = wdata_q;
        idata_d    = idata_q;
        nbytes_d   = nbytes_q;
        cnt_d      = cnt_q;
        accepted_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (order) begin
                    wdata_d    = o_data;
                    nbytes_d   = size_to_count(size);
                    cnt_d      = size_to_count(size);
                    accepted_d = 1'b1;
                    if (write_flag) begin
                        state_d = ST_TX;
                    end else begin
                        state_d = ST_RX;
                        idata_d = 32'd0;
                    end
                end
            end
            ST_TX: begin
                if (tx_ready) begin
                    if (cnt_q != 3'd0) begin
                        cnt_d = cnt_q - 3'd1;
                    end
                    if (cnt_q <= 3'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RX: begin
                if (rx_valid) begin
                    if (cnt_q != 3'd0) begin
                        cnt_d = cnt_q - 3'd1;
`ifdef UART_SERDES_LITTLE_ENDIAN_EN
                        case (pos)
                            3'd0:    idata_d[7:0]   = rx_data;
                            3'd1:    idata_d[15:8]  = rx_data;
                            3'd2:    idata_d[23:16] = rx_data;
                            default: idata_d[31:24] = rx_data;
                        endcase
`else
                        idata_d = {idata_q[23:0], rx_data};
`endif
                    end
                    if (cnt_q <= 3'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            wdata_q    <= 32'd0;
            idata_q    <= 32'd0;
            nbytes_q   <= 3'd0;
            cnt_q      <= 3'd0;
            accepted_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wdata_q    <= wdata_d;
            idata_q    <= idata_d;
            nbytes_q   <= nbytes_d;
            cnt_q      <= cnt_d;
            accepted_q <= accepted_d;
        end
    end

    assign accepted = accepted_q;
    assign done     = (state_q == ST_DONE);
    assign busy     = (state_q != ST_IDLE);
    assign tx_valid = (state_q == ST_TX);
    assign tx_data  = tx_valid ? cur_byte : 8'd0;
    assign rx_ready = (state_q == ST_RX);
    assign i_data   = idata_q;

endmodule
